cordic_rom: RTL and testbench
=============================

// Module: cordic_rom
// PURPOSE
// - Arctangent lookup ROM for the CORDIC rotation datapath: entry i = atan(2^-i) radians.
// - Fixed-point format Q1.31, two's complement: value = round(atan(2^-i) * 2^31).
// - Read by the CORDIC iteration controller, one entry per iteration; output registered, 1-cycle latency.
// PARAMETERS
// - ADDR_W  5   address width; the table has 2^ADDR_W = 32 entries. Only 5 is supported.
// - DATA_W  32  data width; the Q1.31 table is defined only for 32.
// PORTS
// - clk      in   1   single clock, rising edge
// - reset    in   1   synchronous, active-high reset
// - en       in   1   read enable; the output register updates only when en=1
// - address  in   5   iteration index i, 0..31
// - data     out  32  registered atan(2^-i), Q1.31
// - valid    out  1   present only with CORDIC_ROM_VALID_EN; see CONFIGURATION
// BEHAVIOUR
// - All state updates on the rising edge of clk.
// - Reset: the reset input is synchronous and active-high. While reset=1 at a clk edge: data <= 0, valid <= 0.
// - Reset takes priority over en.
// - Read: if reset=0 and en=1 at edge N, then data = ROM[address sampled at edge N] from edge N onward.
//   Latency is 1 cycle.
// - Hold: if en=0, data keeps its previous value. Address changes while en=0 are ignored.
// - Table contents:
//   - Constant, computed offline.
//   - Rounded to nearest; exact halves round up.
//   - All entries positive and strictly non-increasing in i.
// - Key entries:
//   - ROM[0] = 0x6487ED51 (pi/4)
//   - ROM[16] = 0x00008000
//   - ROM[30] = 0x00000002
//   - ROM[31] = 0x00000001
// - For i >= 16: ROM[i] = 2^(31-i). The atan(x) ~= x error is below 1/2 LSB.
// - Every 5-bit address is valid. No wrap or out-of-range case; no X ever driven on data after reset.
// - Back-to-back reads: a new address each cycle with en=1 gives one new entry per cycle, no bubbles.
// - Reset mid-stream: an in-flight read is discarded; data = 0 at the first edge with reset=1.
// - Implementation: case statement / constant array feeding the output register.
// - No RAM inference, no initial-file loading.
// CONFIGURATION
// - Macro CORDIC_ROM_VALID_EN.
// - Defined:
//   - Adds output port valid.
//   - valid <= en on each edge with reset=0; valid <= 0 on reset.
//   - valid=1 marks that data was refreshed by the edge that set it.
// - Undefined:
//   - The valid port and its register are absent.
//   - data behaviour is identical in both builds.
// TESTING
// - Reset: reset=1 for 2 cycles with en=1, address=5 -> data=0x00000000 (valid=0).
// - Sweep: en=1, address 0..31, one per cycle.
//   - data matches the golden round(atan(2^-i)*2^31) table 1 cycle later.
//   - Includes ROM[0]=0x6487ED51 and ROM[31]=0x00000001.
// - Hold: read address 0, then en=0 with address=16 for 3 cycles -> data stays 0x6487ED51.
//   - Then en=1 -> 0x00008000 next cycle.
// - Mid-stream reset: reading address 30 (data=0x00000002); assert reset one cycle -> data=0.
//   - Release reset, read 31 -> 0x00000001.
// - Monotonic check: over the sweep, ROM[i+1] <= ROM[i] and ROM[i] > 0 for all i.
// - With CORDIC_ROM_VALID_EN: en pattern 1,0,1 -> valid pattern 1,0,1 delayed 1 cycle; valid=0 during reset.

Source files
------------

// File: rtl/cordic_rom.sv
// rtl/cordic_rom.sv - atan(2^-i) Q1.31 lookup ROM with registered output; optional valid port via CORDIC_ROM_VALID_EN
module cordic_rom #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data
`ifdef CORDIC_ROM_VALID_EN
   ,
   output logic              valid
`endif
);

   logic [DATA_W-1:0] rom_word;

   // Constant table: round(atan(2^-i) * 2^31). From i = 11 upward the cubic
   // term of atan is under half an LSB, so the entry is exactly 2^(31-i).
   always_comb begin
      rom_word = '0;
      case (address)
         5'd0:    rom_word = 32'h6487_ED51;
         5'd1:    rom_word = 32'h3B58_CE0B;
         5'd2:    rom_word = 32'h1F5B_75F9;
         5'd3:    rom_word = 32'h0FEA_DD4D;
         5'd4:    rom_word = 32'h07FD_56EE;
         5'd5:    rom_word = 32'h03FF_AAB7;
         5'd6:    rom_word = 32'h01FF_F556;
         5'd7:    rom_word = 32'h00FF_FEAB;
         5'd8:    rom_word = 32'h007F_FFD5;
         5'd9:    rom_word = 32'h003F_FFFB;
         5'd10:   rom_word = 32'h001F_FFFF;
         default: rom_word = 32'h8000_0000 >> address;
      endcase
   end

   // Output register: reset clears, en loads the addressed entry, otherwise hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         data <= '0;
      end else if (en) begin
         data <= rom_word;
      end
   end

`ifdef CORDIC_ROM_VALID_EN
   // valid flags that the preceding edge refreshed data.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
      end else begin
         valid <= en;
      end
   end
`endif

endmodule

// File: tb/tb_cordic_rom.sv
// tb/tb_cordic_rom.sv - scoreboard bench for cordic_rom (checks valid when CORDIC_ROM_VALID_EN is defined)
module tb_cordic_rom;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [4:0]  address;
   logic [31:0] data;
`ifdef CORDIC_ROM_VALID_EN
   logic        valid;
`endif

   always #5 clk = ~clk;

   cordic_rom #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .address (address),
      .data    (data)
`ifdef CORDIC_ROM_VALID_EN
      ,
      .valid   (valid)
`endif
   );

   typedef struct {
      logic [31:0] d;
      logic        v;
      int          idx;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_data = 32'h0;
   logic [31:0] sweep_obs[32];

   function automatic logic [31:0] golden(input int i);
      case (i)
         0:  return 32'h6487ED51;
         1:  return 32'h3B58CE0B;
         2:  return 32'h1F5B75F9;
         3:  return 32'h0FEADD4D;
         4:  return 32'h07FD56EE;
         5:  return 32'h03FFAAB7;
         6:  return 32'h01FFF556;
         7:  return 32'h00FFFEAB;
         8:  return 32'h007FFFD5;
         9:  return 32'h003FFFFB;
         10: return 32'h001FFFFF;
         11: return 32'h00100000;
         12: return 32'h00080000;
         13: return 32'h00040000;
         14: return 32'h00020000;
         15: return 32'h00010000;
         16: return 32'h00008000;
         17: return 32'h00004000;
         18: return 32'h00002000;
         19: return 32'h00001000;
         20: return 32'h00000800;
         21: return 32'h00000400;
         22: return 32'h00000200;
         23: return 32'h00000100;
         24: return 32'h00000080;
         25: return 32'h00000040;
         26: return 32'h00000020;
         27: return 32'h00000010;
         28: return 32'h00000008;
         29: return 32'h00000004;
         30: return 32'h00000002;
         default: return 32'h00000001;
      endcase
   endfunction

   // One stimulus cycle: drive on the falling edge, push the value expected after the next rising edge.
   task automatic step(input logic r, input logic e, input logic [4:0] a, input int idx, input string nm);
      exp_t x;
      @(negedge clk);
      reset   = r;
      en      = e;
      address = a;
      if (r)      model_data = 32'h0;
      else if (e) model_data = golden(int'(a));
      x.d    = model_data;
      x.v    = !r && e;
      x.idx  = idx;
      x.name = nm;
      sb.push_back(x);
   endtask

   // Monitor: one scoreboard entry is retired just after every rising edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (data !== x.d) begin
               errors++;
               $display("FAIL %s idx=%0d data=%h expected=%h", x.name, x.idx, data, x.d);
            end
`ifdef CORDIC_ROM_VALID_EN
            checks++;
            if (valid !== x.v) begin
               errors++;
               $display("FAIL %s_valid idx=%0d valid=%b expected=%b", x.name, x.idx, valid, x.v);
            end
`endif
            if (x.idx >= 0) sweep_obs[x.idx] = data;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d expected completion", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int wait_cycles;
      for (int i = 0; i < 32; i++) sweep_obs[i] = 32'h0;
      reset   = 1'b1;
      en      = 1'b0;
      address = 5'd0;

      // Reset with en=1 and a live address must still give zero.
      step(1'b1, 1'b1, 5'd5, -1, "reset_a");
      step(1'b1, 1'b1, 5'd5, -1, "reset_b");

      // Full back-to-back sweep.
      for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 5'(i), i, "sweep");

      // Hold: address changes while en=0 are ignored.
      step(1'b0, 1'b1, 5'd0,  -1, "hold_rd0");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd16, -1, "hold");
      step(1'b0, 1'b1, 5'd16, -1, "hold_rd16");

      // Reset mid-stream discards the in-flight read.
      step(1'b0, 1'b1, 5'd30, -1, "rd30");
      step(1'b1, 1'b1, 5'd31, -1, "mid_reset");
      step(1'b0, 1'b1, 5'd31, -1, "rd31");

      // en pattern 1,0,1.
      step(1'b0, 1'b1, 5'd3, -1, "enpat_1");
      step(1'b0, 1'b0, 5'd7, -1, "enpat_0");
      step(1'b0, 1'b1, 5'd4, -1, "enpat_1b");

      @(negedge clk);
      en = 1'b0;
      wait_cycles = 0;
      while (sb.size() > 0 && wait_cycles < 10) begin
         @(negedge clk);
         wait_cycles++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end

      // Table shape over the observed sweep.
      for (int i = 0; i < 31; i++) begin
         checks++;
         if (sweep_obs[i+1] <= sweep_obs[i]) begin
         end else begin
            errors++;
            $display("FAIL monotonic i=%0d rom[i+1]=%h expected <= rom[i]=%h", i, sweep_obs[i+1], sweep_obs[i]);
         end
      end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (sweep_obs[i] > 32'h0) begin
         end else begin
            errors++;
            $display("FAIL positive i=%0d rom=%h expected > 0", i, sweep_obs[i]);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
